// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Shared types and default constants for the switch ingress path.
//   arb_state_t     : packet arbiter FSM state (IDLE / HEADER / PAYLOAD)
//   byte_t          : one byte of the ingress stream
//   DEF_NUM_SRC     : default number of requesting sources
//   DEF_HDR_LEN     : default header length in bytes (DA, SA, LEN)
//   DEF_LEN_OFFSET  : default header index of the payload-length byte
// -----------------------------------------------------------------------------
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } arb_state_t;

    typedef logic [7:0] byte_t;

    localparam int DEF_NUM_SRC    = 4;
    localparam int DEF_HDR_LEN    = 3;
    localparam int DEF_LEN_OFFSET = 2;

endpackage : switch_pkg

// File: rtl/ingress_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req starting at ptr+1 and
// wrapping modulo NUM_SRC, so the source at ptr (last served) has the
// lowest priority.
//   req     in   NUM_SRC  request vector
//   ptr     in   ID_W     index of the most recently served source
//   gnt_id  out  ID_W     first requesting index after ptr (0 when none)
//   gnt_vld out  1        at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_vld
);

    // Request vector rotated so that rot_req[k] is the source at ptr+1+k.
    logic [NUM_SRC-1:0] rot_req;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rot
            always_comb begin
                int src_idx;
                src_idx     = (int'(ptr) + 1 + gi) % NUM_SRC;
                rot_req[gi] = req[src_idx];
            end
        end
    endgenerate

    // Priority-encode the rotated vector, then map back to a source index.
    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!gnt_vld && rot_req[k]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'((int'(ptr) + 1 + k) % NUM_SRC);
            end
        end
    end

endmodule : rr_pick

// File: rtl/ingress_rr_arbiter.sv
// -----------------------------------------------------------------------------
// ingress_rr_arbiter
// Packet-level round-robin arbiter sharing the switch ingress byte stream
// between NUM_SRC sources. A source is granted for a whole packet (HDR_LEN
// header bytes plus LEN payload bytes, LEN taken from header byte LEN_OFFSET),
// transfers stall while fifo_full is high, and priority rotates after every
// packet. Bytes pass through combinationally; grant takes one idle cycle.
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high
//   src_valid    in   per-source byte valid
//   src_data     in   per-source byte, packed [NUM_SRC-1:0][7:0]
//   src_ready    out  per-source accept (only the granted source, never while full)
//   fifo_full    in   downstream ingress FIFO full
//   data         out  byte to the ingress FIFO (0 when idle)
//   data_status  out  write strobe to the ingress FIFO
//   grant_id     out  currently granted source (holds last value when idle)
//   busy         out  packet in progress
//   pkt_done     out  pulse with the final byte of a packet
// -----------------------------------------------------------------------------
module ingress_rr_arbiter
    import switch_pkg::*;
#(
    parameter  int NUM_SRC    = DEF_NUM_SRC,
    parameter  int HDR_LEN    = DEF_HDR_LEN,
    parameter  int LEN_OFFSET = DEF_LEN_OFFSET,
    localparam int ID_W       = $clog2(NUM_SRC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC-1:0][7:0] src_data,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic                    fifo_full,
    output logic [7:0]              data,
    output logic                    data_status,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    pkt_done
);

    localparam int               HC_W     = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;
    localparam logic [HC_W-1:0]  LEN_IDX  = HC_W'(LEN_OFFSET);
    localparam logic [HC_W-1:0]  LAST_HDR = HC_W'(HDR_LEN - 1);
    localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_SRC - 1);

    arb_state_t      state_q,   state_d;
    logic [ID_W-1:0] grant_q,   grant_d;
    logic [ID_W-1:0] ptr_q,     ptr_d;
    logic [HC_W-1:0] hdr_cnt_q, hdr_cnt_d;
    byte_t           len_q,     len_d;
    byte_t           pay_cnt_q, pay_cnt_d;

    logic [ID_W-1:0] pick_id;
    logic            pick_vld;
    byte_t           cur_byte;
    byte_t           live_len;
    logic            accept;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req     (src_valid),
        .ptr     (ptr_q),
        .gnt_id  (pick_id),
        .gnt_vld (pick_vld)
    );

    // Output path: everything below is a pure function of registered state
    // and live inputs, so reset forces all outputs low immediately.
    assign busy     = (state_q != IDLE);
    assign cur_byte = src_data[grant_q];
    assign accept   = busy && !fifo_full && src_valid[grant_q];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
            assign src_ready[gi] = busy && (grant_q == ID_W'(gi)) && !fifo_full;
        end
    endgenerate

    assign data        = busy ? cur_byte : 8'h00;
    assign data_status = accept;
    assign grant_id    = grant_q;

    // When the length byte is also the last header byte it has not reached
    // len_q yet, so the end-of-header decision must use the live byte.
    assign live_len = (hdr_cnt_q == LEN_IDX) ? cur_byte : len_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        hdr_cnt_d = hdr_cnt_q;
        len_d     = len_q;
        pay_cnt_d = pay_cnt_q;
        pkt_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d   = pick_id;
                    hdr_cnt_d = '0;
                    state_d   = HEADER;
                end
            end

            HEADER: begin
                if (accept) begin
                    if (hdr_cnt_q == LEN_IDX) begin
                        len_d = cur_byte;
                    end
                    if (hdr_cnt_q == LAST_HDR) begin
                        hdr_cnt_d = '0;
                        if (live_len == 8'h00) begin
                            pkt_done = 1'b1;
                            ptr_d    = grant_q;
                            state_d  = IDLE;
                        end else begin
                            pay_cnt_d = 8'h00;
                            state_d   = PAYLOAD;
                        end
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 1'b1;
                    end
                end
            end

            PAYLOAD: begin
                if (accept) begin
                    // 9-bit compare so pay_cnt never has to reach 256.
                    if (({1'b0, pay_cnt_q} + 9'd1) == {1'b0, len_q}) begin
                        pkt_done = 1'b1;
                        ptr_d    = grant_q;
                        state_d  = IDLE;
                    end else begin
                        pay_cnt_d = pay_cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= PTR_INIT;
            hdr_cnt_q <= '0;
            len_q     <= 8'h00;
            pay_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            hdr_cnt_q <= hdr_cnt_d;
            len_q     <= len_d;
            pay_cnt_q <= pay_cnt_d;
        end
    end

endmodule : ingress_rr_arbiter
